// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the carry chain is cut into STAGES equal slices, one per stage,
// with valid/ready flow control. Define ADDER_SAT_EN to add the sat_i saturating mode.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
`ifdef ADDER_SAT_EN
    input  logic             sat_i,
`endif
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int S = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> S;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // Flow control: stage k can take new data when empty or when it is moving on itself.
    logic [STAGES-1:0] vld_q, vld_d, vin, can, en;
    logic              chain;

    assign vin = STAGES'({vld_q, valid_i});

    always_comb begin
        can   = '0;
        chain = ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            can[k] = !vld_q[k] || chain;
            chain  = can[k];
        end
    end

    assign en      = vin & can;
    assign vld_d   = (vin & can) | (vld_q & ~can);
    assign ready_o = can[0];
    assign valid_o = vld_q[STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) vld_q <= '0;
        else          vld_q <= vld_d;
    end

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] acc_f;
    logic [S-1:0]     b_f;
    logic             c_f;
`ifdef ADDER_SAT_EN
    logic             sat_f;
`endif

    assign bx = b_i ^ {WIDTH{sub_i}};

    // acc holds finished sum slices below the current slice and untouched a-slices above it;
    // b remainders are packed into one bus, stage k owning WIDTH-(k+1)*S bits.
    if (STAGES > 1) begin : g_pipe
        localparam int BT = WIDTH * (STAGES - 1) / 2;
        logic [STAGES-2:0][WIDTH-1:0] acc_q;
        logic [BT-1:0]                brem_q;
        logic [STAGES-2:0]            c_q;
`ifdef ADDER_SAT_EN
        logic [STAGES-2:0]            sat_q;
`endif
        for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
            localparam int R   = WIDTH - (k + 1) * S;
            localparam int OFF = k * WIDTH - S * k * (k + 1) / 2;
            logic [WIDTH-1:0] acc_in;
            logic [R+S-1:0]   b_in;
            logic             c_in;
            logic [S:0]       sum;
`ifdef ADDER_SAT_EN
            logic             sat_in;
`endif
            if (k == 0) begin : g_src
                assign acc_in = a_i;
                assign b_in   = bx;
                assign c_in   = sub_i;
`ifdef ADDER_SAT_EN
                assign sat_in = sat_i;
`endif
            end else begin : g_src
                localparam int POFF = OFF - R - S;
                assign acc_in = acc_q[k-1];
                assign b_in   = brem_q[POFF +: R+S];
                assign c_in   = c_q[k-1];
`ifdef ADDER_SAT_EN
                assign sat_in = sat_q[k-1];
`endif
            end

            assign sum = {1'b0, acc_in[k*S +: S]} + {1'b0, b_in[S-1:0]} + {{S{1'b0}}, c_in};

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    acc_q[k]         <= '0;
                    brem_q[OFF +: R] <= '0;
                    c_q[k]           <= 1'b0;
`ifdef ADDER_SAT_EN
                    sat_q[k]         <= 1'b0;
`endif
                end else if (en[k]) begin
                    acc_q[k]             <= acc_in;
                    acc_q[k][k*S +: S]   <= sum[S-1:0];
                    brem_q[OFF +: R]     <= b_in[S +: R];
                    c_q[k]               <= sum[S];
`ifdef ADDER_SAT_EN
                    sat_q[k]             <= sat_in;
`endif
                end
            end
        end

        assign acc_f = acc_q[STAGES-2];
        assign b_f   = brem_q[BT-S +: S];
        assign c_f   = c_q[STAGES-2];
`ifdef ADDER_SAT_EN
        assign sat_f = sat_q[STAGES-2];
`endif
    end else begin : g_single
        assign acc_f = a_i;
        assign b_f   = bx;
        assign c_f   = sub_i;
`ifdef ADDER_SAT_EN
        assign sat_f = sat_i;
`endif
    end

    // Final slice; its top bits are the operand MSBs, so the flags come from here.
    logic [S:0]       sum_f;
    logic [WIDTH-1:0] y_raw, y_d;
    logic             a_msb, b_msb, ovf_d;
    logic [WIDTH-1:0] y_q;
    logic             carry_q, ovf_q, zero_q;

    assign a_msb = acc_f[WIDTH-1];
    assign b_msb = b_f[S-1];
    assign sum_f = {1'b0, acc_f[WIDTH-S +: S]} + {1'b0, b_f} + {{S{1'b0}}, c_f};
    assign y_raw = (acc_f & LO_MASK) | (WIDTH'(sum_f[S-1:0]) << (WIDTH - S));
    assign ovf_d = (a_msb == b_msb) && (sum_f[S-1] != a_msb);
`ifdef ADDER_SAT_EN
    assign y_d   = (sat_f && ovf_d) ? {a_msb, {(WIDTH-1){~a_msb}}} : y_raw;
`else
    assign y_d   = y_raw;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            y_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (en[STAGES-1]) begin
            y_q     <= y_d;
            carry_q <= sum_f[S];
            ovf_q   <= ovf_d;
            zero_q  <= ~|y_d;
        end
    end

    assign y_o        = y_q;
    assign carry_o    = carry_q;
    assign overflow_o = ovf_q;
    assign zero_o     = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed plan steps plus random traffic, checked against an
// arithmetic model with a result queue and a release-time rule for valid_o.
module tb_pipelined_adder;
    localparam int W  = 32;
    localparam int ST = 4;
`ifdef ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [W-1:0] a_i, b_i, y_o;
    logic         sub_i, valid_i, ready_o, carry_o, overflow_o, zero_o, valid_o, ready_i;
`ifdef ADDER_SAT_EN
    logic         sat_i;
`endif

    pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .a_i(a_i), .b_i(b_i), .sub_i(sub_i),
`ifdef ADDER_SAT_EN
        .sat_i(sat_i),
`endif
        .valid_i(valid_i), .ready_o(ready_o), .y_o(y_o), .carry_o(carry_o),
        .overflow_o(overflow_o), .zero_o(zero_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] y;
        logic         c, o, z;
        int           vis;
    } ent_t;

    ent_t         q[$];
    int           checks = 0, errors = 0, cyc = 0;
    bit           stalled = 1'b0, acc_last = 1'b0;
    logic [W-1:0] held = '0;

    function automatic ent_t model(input logic [W-1:0] a, b, input logic s, input logic st);
        ent_t         e;
        logic [W-1:0] bb;
        logic [W:0]   t;
        bb  = s ? ~b : b;
        t   = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
        e.y = t[W-1:0];
        e.c = t[W];
        e.o = (a[W-1] == bb[W-1]) && (e.y[W-1] != a[W-1]);
        if (SAT && st && e.o) e.y = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        e.z   = (e.y == '0);
        e.vis = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the falling edge, check before the rising edge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic st, input logic r);
        ent_t e;
        bit   exp_v;
        valid_i = v; a_i = a; b_i = b; sub_i = s; ready_i = r;
`ifdef ADDER_SAT_EN
        sat_i = st;
`endif
        #1;
        exp_v = (q.size() > 0) && (cyc >= q[0].vis);
        chk("valid_o", W'(valid_o), W'(exp_v));
        chk("ready_o", W'(ready_o), W'(r || (q.size() < ST)));
        if (stalled && valid_o) chk("hold_y", y_o, held);
        if (valid_o && q.size() > 0) begin
            chk("y_o", y_o, q[0].y);
            chk("carry_o", W'(carry_o), W'(q[0].c));
            chk("overflow_o", W'(overflow_o), W'(q[0].o));
            chk("zero_o", W'(zero_o), W'(q[0].z));
            if (r) begin
                void'(q.pop_front());
                if (q.size() > 0 && q[0].vis < cyc + 1) begin
                    e = q.pop_front();
                    e.vis = cyc + 1;
                    q.push_front(e);
                end
            end
        end
        stalled  = valid_o && !r;
        held     = y_o;
        acc_last = v && ready_o;
        if (acc_last) begin
            e = model(a, b, s, st);
            e.vis = cyc + ST;
            q.push_back(e);
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("drain_empty", W'(q.size()), '0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n_i = 1'b1; valid_i = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0; ready_i = 1'b0;
`ifdef ADDER_SAT_EN
        sat_i = 1'b0;
`endif
        #1 rst_n_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        chk("rst_valid_o", W'(valid_o), '0);
        chk("rst_y_o", y_o, '0);
        chk("rst_flags", W'({carry_o, overflow_o, zero_o}), '0);
        rst_n_i = 1'b1;
        #1 chk("rst_ready_o", W'(ready_o), W'(1'b1));

        // single add crossing a slice boundary
        step(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b1);

        // subtract to zero, then borrow
        step(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        drain();

        // overflow / wrap, with sat requested
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        drain();

        // back-pressure: 8 ops, consumer stalls 6 cycles mid-stream
        n = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            step(1'b1, 32'h1000_0001 * (n + 1), 32'h0F0F_0F0F + n, n[0], 1'b0,
                 !(i >= 2 && i < 8));
            if (acc_last) n++;
        end
        chk("bp_accepted", W'(n), W'(8));
        drain();

        // bubble collapse behind a stalled result
        step(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b0);
        drain();

        // asynchronous reset with three ops in flight
        step(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h5555_5555, 32'h6666_6666, 1'b1, 1'b0, 1'b1);
        valid_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        chk("midrst_valid_o", W'(valid_o), '0);
        chk("midrst_y_o", y_o, '0);
        q.delete();
        stalled = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1 chk("postrst_ready_o", W'(ready_o), W'(1'b1));
        idle(6, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b0, 1'b1);
        drain();

        // random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: rb = ~ra;
                2: ra = 32'h7FFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit combinational adder.
- Splits the carry chain into STAGES equal slices, one slice per pipeline stage, so wide adds close timing at processor clock rates.
- Valid/ready handshake on both sides; produces carry, signed-overflow and zero flags.
- Used by the datapath for address/ALU adds where a multi-cycle result is acceptable.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STAGES, 4, pipeline depth and number of carry slices; WIDTH % STAGES == 0 required (elaboration error otherwise); STAGES >= 1.

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- a_i  input  WIDTH  operand a
- b_i  input  WIDTH  operand b
- sub_i  input  1  0: a+b, 1: a-b (a + ~b + 1)
- valid_i  input  1  operands valid
- ready_o  output  1  unit can accept operands
- y_o  output  WIDTH  result
- carry_o  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow_o  output  1  signed two's-complement overflow
- zero_o  output  1  y_o == 0
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts result

Behaviour:
- Reset (rst_n_i low, async): all stage valid bits cleared. valid_o=0; y_o, carry_o, overflow_o, zero_o = 0. ready_o=1 once reset is released. Reset mid-operation discards all in-flight operations; no result is emitted.
- Accept: transfer when valid_i && ready_o at a rising edge. At accept, stage 0 latches a_i, b_i ^ {WIDTH{sub_i}}, carry-in = sub_i and sub_i.
- Slice k (width W/STAGES): stage k adds bits [k*S +: S] with carry from stage k-1. It registers the partial sum, carry and the remaining operand slices.
- Latency: an op accepted at edge N presents valid_o=1 with its result after edge N+STAGES-1, i.e. STAGES cycles from accept to the output register.
- Throughput: 1 op/cycle when ready_i is held high.
- Per-stage advance: stage k loads from stage k-1 when stage k is empty or is itself advancing. The output stage advances when !valid_o || ready_i. Bubbles collapse.
- ready_o = stage 0 empty || stage 0 advancing (combinational from ready_i chain; no registered skid).
- Output hold: while valid_o && !ready_i, y_o and all flags remain stable.
- Flags are computed at the final stage:
  - carry_o = carry out of bit WIDTH-1.
  - overflow_o = (a[MSB]==b'[MSB]) && (y[MSB]!=a[MSB]), where b' is the inverted b for sub.
  - zero_o = ~|y_o.
- Order: results emerge in acceptance order; no reordering.
- Simultaneous accept and emit in the same cycle with full pipeline is supported (every stage advances).
- When valid_o=0, y_o and the flags hold their last value; they are don't-care for the consumer.

Optional Feature:
- Macro ADDER_SAT_EN.
- Defined: extra input port sat_i (1 bit), captured with the operands. When sat_i=1 and overflow occurs, y_o clamps to the signed limit: positive overflow gives 0x7FFF..F, negative gives 0x8000..0. overflow_o still reports 1 and zero_o reflects the clamped value. sat_i=0 wraps as normal.
- Undefined: no sat_i port; results always wrap modulo 2^WIDTH.

Test Plan (WIDTH=32, STAGES=4):
- Single add: a=0x0000_FFFF, b=0x0000_0001, sub=0, ready_i=1 -> valid_o for one cycle, 4 cycles after accept; y=0x0001_0000, carry=0, ovf=0, zero=0 (carry crosses slice boundary).
- Sub and zero: a=0x1234_5678, b=0x1234_5678, sub=1 -> y=0, zero=1, carry=1, ovf=0. Then a=0, b=1, sub=1 -> y=0xFFFF_FFFF, carry=0.
- Overflow/wrap: a=0x7FFF_FFFF, b=1, add -> y=0x8000_0000, ovf=1. a=0xFFFF_FFFF, b=1 -> y=0, carry=1, zero=1. With ADDER_SAT_EN and sat_i=1, the first case gives y=0x7FFF_FFFF, ovf=1.
- Back-pressure: stream 8 ops back-to-back, ready_i low for 6 cycles mid-stream -> ready_o falls after 4 ops are stored; y_o stable while stalled; all 8 results in order; no loss or duplication.
- Bubble collapse: issue op, idle 2 cycles, issue op with ready_i=0 -> second op advances until it sits behind the first; both delivered in order once ready_i=1.
- Reset mid-flight: 3 ops in pipeline, pulse rst_n_i low asynchronously between edges -> valid_o=0 immediately; after release no stale result appears; ready_o=1.
